alu_instr_issuer: RTL and testbench
===================================

// Module: alu_instr_issuer
// PURPOSE
//  Encoder/initiator side of the ALU instruction interface. Accepts abstract op requests
//  (op code, register selects, immediate) over valid/ready, encodes each into a 32-bit
//  MIPS instruction word and drives it to the combinational alu. After ALU_LAT cycles it
//  captures alu result/flags and returns them over a valid/ready response channel.
// PARAMETERS
//  ALU_LAT     1             cycles from driving alu_instr to sampling alu_result/alu_flags (>=1)
//  IDLE_INSTR  32'h00000020  word driven when no op is in flight (add regA,regA; must be legal)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst_n        in   1   synchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   issuer can accept request
//  req_op       in   5   0 add,1 addi,2 addu,3 addiu,4 sub,5 subu,6 and,7 andi,8 nor,9 or,
//                        10 ori,11 xor,12 xori; 13..31 invalid
//  req_rs       in   1   rs select: 0 -> addr 00000 (regA), 1 -> addr 00001 (regB)
//  req_rt       in   1   rt select, same mapping
//  req_imm      in   16  immediate (I-type only; ignored for R-type)
//  alu_instr    out  32  instruction word to alu
//  alu_result   in   32  alu result
//  alu_flags    in   3   alu flags {ovf,neg,zero}
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts response
//  rsp_instr    out  32  encoded word of the completed op (IDLE_INSTR if err)
//  rsp_result   out  32  captured alu_result (0 if err)
//  rsp_flags    out  3   captured alu_flags (0 if err)
//  rsp_err      out  1   request op was invalid; nothing issued
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, alu_instr=IDLE_INSTR, req_ready=1 (after reset),
//   rsp_valid=0, rsp_instr=0, rsp_result=0, rsp_flags=0, rsp_err=0, wait counter=0.
//  Encoding: R-type = {6'b0, 4'b0,rs, 4'b0,rt, 5'b0 rd, 5'b0 shamt, funct};
//   funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101,
//   xor 100110, nor 100111. I-type = {op, 4'b0,rs, 4'b0,rt, req_imm}; op addi 001000,
//   addiu 001001, andi 001100, ori 001101, xori 001110. Immediate passed raw, no extension.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&req_ready: valid op -> register encoded word into
//    alu_instr, load counter=ALU_LAT-1, go WAIT; invalid op -> load rsp_* (err=1,
//    instr=IDLE_INSTR, result/flags 0), go RESP directly, alu_instr stays IDLE_INSTR.
//   WAIT: req_ready=0. Counter nonzero -> decrement. Counter zero -> at that edge capture
//    alu_result/alu_flags into rsp_result/rsp_flags, rsp_instr=alu_instr, rsp_err=0, go RESP.
//   RESP: rsp_valid=1, req_ready=0, alu_instr held. rsp_* stable while rsp_valid&!rsp_ready.
//    On rsp_ready: go IDLE, alu_instr<=IDLE_INSTR, rsp_valid drops next cycle.
//  Latency (ALU_LAT=1): accept at edge k, alu_instr valid after k, capture at k+1, rsp_valid
//   high after k+1. Invalid op: rsp_valid high after k. One op in flight max; no pipelining.
//  Throughput: with rsp_ready held 1, one op per ALU_LAT+2 cycles.
//  alu_instr is never an illegal word (alu halts sim on unrecognized instruction).
//  req_* ignored outside IDLE. Reset mid-WAIT/RESP: abort op, response discarded, all
//   outputs to reset values at that edge.
// TESTING
//  add rs=0 rt=1, regA=3 regB=4 -> alu_instr=0x00010020, rsp_result=7, rsp_flags=000,
//   rsp_valid 2 cycles after accept.
//  addi rs=0 rt=1 imm=0xFFFF, regA=5 -> alu_instr=0x2001FFFF, rsp_result=4, flags=000.
//  sub rs=0 rt=1, regA=0x80000000 regB=1 -> alu_instr=0x00010022, result=0x7FFFFFFF, flags=100.
//  andi rs=1 rt=0 imm=0x8001, regB=0xFFFFFFFF -> alu_instr=0x30208001, result=0x00008001.
//  req_op=20 -> rsp_err=1, result 0, alu_instr stays 0x00000020, rsp_valid 1 cycle after accept.
//  rsp_ready low 5 cycles: rsp_* stable, req_ready=0; then reset in WAIT -> all reset values.

Source files
------------

// File: rtl/alu_instr_issuer.sv
// ALU instruction issuer: encodes abstract op requests into MIPS words,
// drives the combinational ALU and returns the captured result.
module alu_instr_issuer #(
  parameter int          ALU_LAT    = 1,
  parameter logic [31:0] IDLE_INSTR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic        req_rs,
  input  logic        req_rt,
  input  logic [15:0] req_imm,
  output logic [31:0] alu_instr,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic        op_ok;
  logic        is_r;
  logic [5:0]  code;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] enc_word;

  assign rs_addr = {4'b0, req_rs};
  assign rt_addr = {4'b0, req_rt};

  // Map op code to R-type funct or I-type opcode; unknown ops are flagged.
  always_comb begin
    op_ok = 1'b1;
    is_r  = 1'b1;
    code  = 6'b10_0000;
    unique case (req_op)
      5'd0:  code = 6'b10_0000;
      5'd1:  begin is_r = 1'b0; code = 6'b00_1000; end
      5'd2:  code = 6'b10_0001;
      5'd3:  begin is_r = 1'b0; code = 6'b00_1001; end
      5'd4:  code = 6'b10_0010;
      5'd5:  code = 6'b10_0011;
      5'd6:  code = 6'b10_0100;
      5'd7:  begin is_r = 1'b0; code = 6'b00_1100; end
      5'd8:  code = 6'b10_0111;
      5'd9:  code = 6'b10_0101;
      5'd10: begin is_r = 1'b0; code = 6'b00_1101; end
      5'd11: code = 6'b10_0110;
      5'd12: begin is_r = 1'b0; code = 6'b00_1110; end
      default: op_ok = 1'b0;
    endcase
  end

  // Assemble the instruction word; rd and shamt are always zero.
  always_comb begin
    if (is_r)
      enc_word = {6'b0, rs_addr, rt_addr, 5'b0, 5'b0, code};
    else
      enc_word = {code, rs_addr, rt_addr, req_imm};
  end

  // Issue FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_instr  <= IDLE_INSTR;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_instr  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (op_ok) begin
              alu_instr <= enc_word;
              cnt       <= CNT_LOAD;
              state     <= S_WAIT;
            end else begin
              rsp_err    <= 1'b1;
              rsp_instr  <= IDLE_INSTR;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_instr  <= alu_instr;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            alu_instr <= IDLE_INSTR;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_instr <= IDLE_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Testbench for alu_instr_issuer: directed vectors, corner sequences
// and randomized ops against an op-level reference model.
module tb_alu_instr_issuer;

  localparam int          ALU_LAT = 1;
  localparam logic [31:0] IDLE    = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic        req_rs;
  logic        req_rt;
  logic [15:0] req_imm;
  logic [31:0] alu_instr;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;

  logic [31:0] reg_a;
  logic [31:0] reg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_instr_issuer #(.ALU_LAT(ALU_LAT), .IDLE_INSTR(IDLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
    .alu_instr(alu_instr), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Combinational ALU stand-in: decodes the word on alu_instr.
  logic [31:0] sa, sb, sx, zx, r;
  logic        ov, legal;
  always_comb begin
    sa = alu_instr[21] ? reg_b : reg_a;
    sb = alu_instr[16] ? reg_b : reg_a;
    sx = {{16{alu_instr[15]}}, alu_instr[15:0]};
    zx = {16'b0, alu_instr[15:0]};
    r = '0;
    ov = 1'b0;
    legal = (alu_instr[25:22] == 4'b0) && (alu_instr[20:17] == 4'b0);
    if (alu_instr[31:26] == 6'h00) begin
      if (alu_instr[15:6] != 10'b0) legal = 1'b0;
      case (alu_instr[5:0])
        6'h20: begin r = sa + sb; ov = (sa[31] == sb[31]) && (r[31] != sa[31]); end
        6'h21: r = sa + sb;
        6'h22: begin r = sa - sb; ov = (sa[31] != sb[31]) && (r[31] != sa[31]); end
        6'h23: r = sa - sb;
        6'h24: r = sa & sb;
        6'h25: r = sa | sb;
        6'h26: r = sa ^ sb;
        6'h27: r = ~(sa | sb);
        default: legal = 1'b0;
      endcase
    end else begin
      case (alu_instr[31:26])
        6'h08: begin r = sa + sx; ov = (sa[31] == sx[31]) && (r[31] != sa[31]); end
        6'h09: r = sa + sx;
        6'h0C: r = sa & zx;
        6'h0D: r = sa | zx;
        6'h0E: r = sa ^ zx;
        default: legal = 1'b0;
      endcase
    end
    alu_result = r;
    alu_flags  = {ov, r[31], r == 32'b0};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The ALU must never see an unrecognized word while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!legal) begin
        errors++;
        $display("FAIL alu_legal: got %h expected legal word", alu_instr);
      end
    end
  end

  // Reference model at op level: semantics straight from the op table.
  function automatic void model(
    input  logic [4:0]  op,
    input  logic        rs,
    input  logic        rt,
    input  logic [15:0] imm,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic [31:0] ins,
    output logic [31:0] res,
    output logic [2:0]  fl,
    output logic        err
  );
    logic [31:0] s, t, se, ze;
    logic [5:0]  code;
    logic        rtype, ovf;
    longint      sv;
    s = rs ? rb : ra;
    t = rt ? rb : ra;
    se = {{16{imm[15]}}, imm};
    ze = {16'b0, imm};
    ovf = 1'b0;
    err = 1'b0;
    rtype = 1'b1;
    code = 6'h00;
    res = '0;
    sv = 0;
    case (op)
      5'd0:  begin code = 6'h20; sv = longint'($signed(s)) + longint'($signed(t)); res = s + t; end
      5'd1:  begin rtype = 0; code = 6'h08; sv = longint'($signed(s)) + longint'($signed(se)); res = s + se; end
      5'd2:  begin code = 6'h21; res = s + t; end
      5'd3:  begin rtype = 0; code = 6'h09; res = s + se; end
      5'd4:  begin code = 6'h22; sv = longint'($signed(s)) - longint'($signed(t)); res = s - t; end
      5'd5:  begin code = 6'h23; res = s - t; end
      5'd6:  begin code = 6'h24; res = s & t; end
      5'd7:  begin rtype = 0; code = 6'h0C; res = s & ze; end
      5'd8:  begin code = 6'h27; res = ~(s | t); end
      5'd9:  begin code = 6'h25; res = s | t; end
      5'd10: begin rtype = 0; code = 6'h0D; res = s | ze; end
      5'd11: begin code = 6'h26; res = s ^ t; end
      5'd12: begin rtype = 0; code = 6'h0E; res = s ^ ze; end
      default: err = 1'b1;
    endcase
    if (op == 5'd0 || op == 5'd1 || op == 5'd4)
      ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    if (err) begin
      ins = IDLE;
      res = '0;
      fl  = '0;
    end else begin
      ins = rtype ? {6'b0, 4'b0, rs, 4'b0, rt, 10'b0, code}
                  : {code, 4'b0, rs, 4'b0, rt, imm};
      fl = {ovf, res[31], res == 32'b0};
    end
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_alu_instr"}, alu_instr, IDLE);
    chk({tag, "_rsp_instr"}, rsp_instr, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Issue one op, check latency, hold the response for `hold` cycles, release.
  task automatic run_op(
    input logic [4:0]  op,
    input logic        rs,
    input logic        rt,
    input logic [15:0] imm,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] e_ins,
    input logic [31:0] e_res,
    input logic [2:0]  e_fl,
    input logic        e_err,
    input int          hold
  );
    int lat;
    @(negedge clk);
    reg_a = a;
    reg_b = b;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_rs = rs;
    req_rt = rt;
    req_imm = imm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 5'($urandom);
    req_imm = 16'($urandom);
    chk("alu_instr_issue", alu_instr, e_err ? IDLE : e_ins);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), e_err ? 32'd0 : 32'(ALU_LAT));
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("rsp_instr", rsp_instr, e_ins);
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_flags", 32'(rsp_flags), 32'(e_fl));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      if (h < hold) begin
        @(posedge clk);
        #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("alu_instr_idle", alu_instr, IDLE);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        rs;
    logic        rt;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ins;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [4:0]  op;
    logic [15:0] imm;
    logic [31:0] a, b, e_ins, e_res;
    logic [2:0]  e_fl;
    logic        e_err, rs, rt;

    vecs[0] = '{5'd0,  1'b0, 1'b1, 16'h0000, 32'd3, 32'd4,
                32'h0001_0020, 32'd7, 3'b000, 1'b0};
    vecs[1] = '{5'd1,  1'b0, 1'b1, 16'hFFFF, 32'd5, 32'd0,
                32'h2001_FFFF, 32'd4, 3'b000, 1'b0};
    vecs[2] = '{5'd4,  1'b0, 1'b1, 16'h0000, 32'h8000_0000, 32'd1,
                32'h0001_0022, 32'h7FFF_FFFF, 3'b100, 1'b0};
    vecs[3] = '{5'd7,  1'b1, 1'b0, 16'h8001, 32'd0, 32'hFFFF_FFFF,
                32'h3020_8001, 32'h0000_8001, 3'b000, 1'b0};
    vecs[4] = '{5'd20, 1'b0, 1'b1, 16'h1234, 32'd9, 32'd9,
                IDLE, 32'd0, 3'b000, 1'b1};
    vecs[5] = '{5'd8,  1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFF, 32'd0,
                32'h0000_0027, 32'd0, 3'b001, 1'b0};
    vecs[6] = '{5'd12, 1'b1, 1'b1, 16'h00FF, 32'd0, 32'h8000_0000,
                32'h3821_00FF, 32'h8000_00FF, 3'b010, 1'b0};
    vecs[7] = '{5'd2,  1'b1, 1'b1, 16'h0000, 32'd0, 32'h7FFF_FFFF,
                32'h0021_0021, 32'hFFFF_FFFE, 3'b010, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_rs = 1'b0;
    req_rt = 1'b0;
    req_imm = '0;
    rsp_ready = 1'b0;
    reg_a = '0;
    reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm,
             vecs[i].a, vecs[i].b, vecs[i].ins, vecs[i].res,
             vecs[i].fl, vecs[i].err, 0);

    // Backpressure for 5 cycles, then abort an op with reset in WAIT.
    run_op(5'd0, 1'b0, 1'b1, 16'h0, 32'd3, 32'd4,
           32'h0001_0020, 32'd7, 3'b000, 1'b0, 5);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'd4;
    req_rs = 1'b1;
    req_rt = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wait_state_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_wait");
    rst_n = 1'b1;

    // Reset while a response is pending is discarded too.
    run_op(5'd20, 1'b0, 1'b0, 16'h0, 32'd1, 32'd2,
           IDLE, 32'd0, 3'b000, 1'b1, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("resp_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_resp");
    rst_n = 1'b1;

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0)
        op = 5'($urandom_range(13, 31));
      else
        op = 5'($urandom_range(0, 12));
      rs = 1'($urandom);
      rt = 1'($urandom);
      imm = 16'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) b = 32'h7FFF_FFFF;
      model(op, rs, rt, imm, a, b, e_ins, e_res, e_fl, e_err);
      run_op(op, rs, rt, imm, a, b, e_ins, e_res, e_fl, e_err,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
